// File: rtl/fwd_source_tracker_if.sv
// Bundle between the decode stage (master) and the forwarding source tracker (slave).
// Issue handshake: an instruction transfers into S1 on a rising clock edge when
// issue_valid=1 and stall=0 (stall is the inverted ready). While stall=1 the issue_*
// fields are ignored and the decode stage re-presents the instruction later.
interface fwd_source_tracker_if #(
    parameter int REG_ADDRESS_LENGTH = 5,
    parameter int DATA_WIDTH         = 64
);
    logic                          issue_valid;
    logic [REG_ADDRESS_LENGTH-1:0] issue_rd;
    logic                          issue_wr_en;
    logic                          issue_is_load;
    logic [DATA_WIDTH-1:0]         ex_result;
    logic                          mem_data_valid;
    logic [DATA_WIDTH-1:0]         mem_data;
    logic [REG_ADDRESS_LENGTH-1:0] current_RA;
    logic [REG_ADDRESS_LENGTH-1:0] current_RB;
    logic                          stall;
    logic [1:0]                    fwd_sel_rA;
    logic [DATA_WIDTH-1:0]         fwd_data_rA;
    logic [1:0]                    fwd_sel_rB;
    logic [DATA_WIDTH-1:0]         fwd_data_rB;
    logic                          wb_valid;
    logic [REG_ADDRESS_LENGTH-1:0] wb_rd;
    logic [DATA_WIDTH-1:0]         wb_data;

    modport master (
        output issue_valid, issue_rd, issue_wr_en, issue_is_load,
        output ex_result, mem_data_valid, mem_data, current_RA, current_RB,
        input  stall, fwd_sel_rA, fwd_data_rA, fwd_sel_rB, fwd_data_rB,
        input  wb_valid, wb_rd, wb_data
    );

    modport slave (
        input  issue_valid, issue_rd, issue_wr_en, issue_is_load,
        input  ex_result, mem_data_valid, mem_data, current_RA, current_RB,
        output stall, fwd_sel_rA, fwd_data_rA, fwd_sel_rB, fwd_data_rB,
        output wb_valid, wb_rd, wb_data
    );
endinterface

// File: rtl/fwd_source_tracker.sv
// Operand-forwarding source tracker: follows destination registers through EX (S1),
// MEM (S2) and WB (S3), returns per-operand forward select/data and a decode stall,
// and drives the register-file write port from S3.
// Optional feature macro: ZERO_REG_EN (register 0 hardwired to zero).
module fwd_source_tracker #(
    parameter int REG_ADDRESS_LENGTH = 5,
    parameter int DATA_WIDTH         = 64
) (
    input logic                 clk,
    input logic                 reset,
    fwd_source_tracker_if.slave bus
);
    localparam int RAL = REG_ADDRESS_LENGTH;
    localparam int DW  = DATA_WIDTH;

    typedef struct packed {
        logic           valid;
        logic [RAL-1:0] rd;
        logic           wr;
        logic           is_load;
        logic [DW-1:0]  data;
    } slot_t;

    typedef struct packed {
        logic [1:0]    sel;
        logic [DW-1:0] data;
        logic          hazard;
    } fwd_t;

    slot_t s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic  freeze;
    logic  stall;
    logic  issue_wr;
    fwd_t  fwd_a, fwd_b;

    // Youngest matching slot wins; the register file is never write-before-read, so S3
    // must still be forwarded.
    function automatic fwd_t resolve(input logic [RAL-1:0] src, input slot_t s1,
                                     input slot_t s2, input slot_t s3,
                                     input logic [DW-1:0] ex, input logic mdv,
                                     input logic [DW-1:0] md);
        fwd_t r;
        r = '0;
        if (s1.valid && s1.wr && s1.rd == src) begin
            r.sel = 2'b01;
            if (s1.is_load) r.hazard = 1'b1;
            else            r.data   = ex;
        end else if (s2.valid && s2.wr && s2.rd == src) begin
            r.sel = 2'b10;
            if (!s2.is_load)  r.data   = s2.data;
            else if (mdv)     r.data   = md;
            else              r.hazard = 1'b1;
        end else if (s3.valid && s3.wr && s3.rd == src) begin
            r.sel  = 2'b11;
            r.data = s3.data;
        end
        return r;
    endfunction

`ifdef ZERO_REG_EN
    // Writes to register 0 are dropped at issue so they can never match or write back.
    assign issue_wr = bus.issue_wr_en && (bus.issue_rd != '0);
`else
    assign issue_wr = bus.issue_wr_en;
`endif

    // Operand resolution, memory-wait freeze and the combined decode stall.
    always_comb begin
        fwd_a  = resolve(bus.current_RA, s1_q, s2_q, s3_q, bus.ex_result,
                         bus.mem_data_valid, bus.mem_data);
        fwd_b  = resolve(bus.current_RB, s1_q, s2_q, s3_q, bus.ex_result,
                         bus.mem_data_valid, bus.mem_data);
        freeze = s2_q.valid && s2_q.is_load && s2_q.wr && !bus.mem_data_valid;
        stall  = freeze || fwd_a.hazard || fwd_b.hazard;
    end

    // Pipeline advance: hold everything while frozen, otherwise shift and capture results.
    always_comb begin
        s1_d = s1_q;
        s2_d = s2_q;
        s3_d = s3_q;
        if (!freeze) begin
            s3_d = s2_q;
            if (s2_q.is_load) s3_d.data = bus.mem_data;
            s2_d      = s1_q;
            s2_d.data = s1_q.is_load ? '0 : bus.ex_result;
            s1_d      = '0;
            if (bus.issue_valid && !stall) begin
                s1_d.valid   = 1'b1;
                s1_d.rd      = bus.issue_rd;
                s1_d.wr      = issue_wr;
                s1_d.is_load = bus.issue_is_load;
            end
        end
    end

    // Slot registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign bus.stall       = stall;
    assign bus.fwd_sel_rA  = fwd_a.sel;
    assign bus.fwd_data_rA = fwd_a.data;
    assign bus.fwd_sel_rB  = fwd_b.sel;
    assign bus.fwd_data_rB = fwd_b.data;
    // A frozen S3 is the same instruction as last cycle, so it must not write again.
    assign bus.wb_valid    = s3_q.valid && s3_q.wr && !freeze;
    assign bus.wb_rd       = s3_q.rd;
    assign bus.wb_data     = s3_q.data;
endmodule
